diff_sequencer: RTL

Streams a stored vector of pre-activation values through the shared combinational activation-derivative unit, one `lanes`-wide chunk per cycle. It is the backprop-side controller that owns the derivative unit. On `start` it latches base address, destination address, chunk count and activation type. It then issues synchronous reads from the pre-activation buffer, routes each chunk through the derivative unit, and writes the results to the gradient buffer. Throughput is one chunk per cycle, and completion is signalled with a one-cycle `done` pulse.

---
 rtl/diff_sequencer.sv | 123 ++++++++++++
 1 files changed

// File: rtl/diff_sequencer.sv
// Streams pre-activation chunks from a buffer through the shared derivative unit into the gradient buffer.
// Latency 3 cycles from start to first write, 3+N to done; no backpressure, start is ignored while a job runs.
module diff_sequencer #(
  parameter int lanes         = 3,
  parameter int data_size     = 16,
  parameter int act_type_size = 4,
  parameter int addr_size     = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [addr_size-1:0]         src_base,
  input  logic [addr_size-1:0]         dst_base,
  input  logic [addr_size-1:0]         num_chunks,
  input  logic [act_type_size-1:0]     act_type_in,
  output logic                         busy,
  output logic                         done,
  output logic                         rd_en,
  output logic [addr_size-1:0]         rd_addr,
  input  logic [lanes*data_size-1:0]   rd_data,
  output logic [lanes*data_size-1:0]   diff_x,
  output logic [act_type_size-1:0]     diff_act_type,
  input  logic [lanes*data_size-1:0]   diff_y,
  output logic                         wr_en,
  output logic [addr_size-1:0]         wr_addr,
  output logic [lanes*data_size-1:0]   wr_data
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE_S} state_t;

  localparam logic [addr_size-1:0] ADDR_ONE = addr_size'(1);

  state_t               state;
  logic [addr_size-1:0] dst_lat;
  logic [addr_size-1:0] num_lat;
  logic [addr_size-1:0] rd_cnt;
  logic [addr_size-1:0] wr_cnt;
  logic                 s1_vld;

  // Control FSM and read pointer; rd_cnt counts reads already issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      rd_en         <= 1'b0;
      rd_addr       <= '0;
      dst_lat       <= '0;
      num_lat       <= '0;
      rd_cnt        <= '0;
      diff_act_type <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            diff_act_type <= act_type_in;
            dst_lat       <= dst_base;
            num_lat       <= num_chunks;
            if (num_chunks != '0) begin
              state   <= RUN;
              busy    <= 1'b1;
              rd_en   <= 1'b1;
              rd_addr <= src_base;
              rd_cnt  <= ADDR_ONE;
            end else begin
              state <= DONE_S;
              done  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (rd_cnt == num_lat) begin
            rd_en <= 1'b0;
            state <= DRAIN;
          end else begin
            rd_addr <= rd_addr + ADDR_ONE;
            rd_cnt  <= rd_cnt + ADDR_ONE;
          end
        end
        DRAIN: begin
          // Once stage 1 empties, the final write is on the bus this cycle.
          if (!s1_vld) begin
            state <= DONE_S;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) s1_vld <= 1'b0;
    else       s1_vld <= rd_en;
  end

  assign diff_x = s1_vld ? rd_data : '0;

  // Stage 2 captures the combinational derivative result.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      wr_cnt  <= '0;
    end else begin
      wr_en <= s1_vld;
      if (s1_vld) begin
        wr_data <= diff_y;
        wr_addr <= dst_lat + wr_cnt;
        wr_cnt  <= wr_cnt + ADDR_ONE;
      end else if (state == IDLE && start) begin
        wr_cnt <= '0;
      end
    end
  end

endmodule
